// File: rtl/alu_writeback_stage_if.sv
// Issue-side and register_file-side signals of the ALU writeback stage.
// The master drives requests and read data; the slave (the stage) returns addresses, write data and flags.
interface alu_writeback_stage_if #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [ADDR-1:0]  ra, rb, rd;
  logic [ADDR-1:0]  Ra, Rb, Rw;
  logic [WIDTH-1:0] busA, busB, busW;
  logic             wrEn;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, op, ra, rb, rd, busA, busB,
    input  in_ready, Ra, Rb, Rw, busW, wrEn, zero, ovf
  );
  modport slave (
    input  in_valid, op, ra, rb, rd, busA, busB,
    output in_ready, Ra, Rb, Rw, busW, wrEn, zero, ovf
  );
endinterface

// File: rtl/alu_writeback_stage.sv
// Execute/writeback stage: single-cycle ALU ops plus a WIDTH-cycle shift-add multiplier,
// with a 1-deep forward of the pending register_file write.
module alu_writeback_stage #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 5
) (
  input logic                  clk,
  input logic                  rst,
  alu_writeback_stage_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] op_a, op_b, result;
  logic [WIDTH-1:0] mcand, mplier, acc, mul_next;
  logic [ADDR-1:0]  mul_rd;
  logic [3:0]       sh;
  logic             res_ovf, accept;

  assign bus.in_ready = (state == IDLE);
  assign bus.Ra       = bus.ra;
  assign bus.Rb       = bus.rb;
  assign accept       = bus.in_valid & bus.in_ready;

  // busW is valid while wrEn is high but register_file commits it only at the coming edge
  assign op_a = (bus.wrEn && bus.Rw == bus.ra) ? bus.busW : bus.busA;
  assign op_b = (bus.wrEn && bus.Rw == bus.rb) ? bus.busW : bus.busB;
  assign sh   = op_b[3:0];

  always_comb begin
    result  = '0;
    res_ovf = 1'b0;
    case (bus.op)
      4'd0: begin
        result  = op_a + op_b;
        res_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (result[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'd1: begin
        result  = op_a - op_b;
        res_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (result[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'd2: result = op_a & op_b;
      4'd3: result = op_a | op_b;
      4'd4: result = op_a ^ op_b;
      4'd5: result = op_a << sh;
      4'd6: result = op_a >> sh;
      4'd7: result = $signed(op_a) >>> sh;
      4'd8: result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd9: result = op_a;
      default: result = '0;
    endcase
  end

  assign mul_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      mul_rd   <= '0;
      bus.Rw   <= '0;
      bus.busW <= '0;
      bus.wrEn <= 1'b0;
      bus.zero <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      bus.wrEn <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (bus.op == 4'd10) begin
            state  <= MUL;
            count  <= '0;
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            mul_rd <= bus.rd;
          end else if (bus.op < 4'd10) begin
            bus.Rw   <= bus.rd;
            bus.busW <= result;
            bus.wrEn <= 1'b1;
            bus.zero <= (result == '0);
            bus.ovf  <= res_ovf;
          end
        end
        MUL: begin
          acc    <= mul_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == LAST) begin
            bus.Rw   <= mul_rd;
            bus.busW <= mul_next;
            bus.wrEn <= 1'b1;
            bus.zero <= (mul_next == '0);
            bus.ovf  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench: register_file model around alu_writeback_stage, hand-computed results.
module tb_alu_writeback_stage;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   wr_cnt = 0;
  int   busy, base;
  logic [15:0] rf [32];

  alu_writeback_stage_if #(.WIDTH(16), .ADDR(5)) bus ();
  alu_writeback_stage #(.WIDTH(16), .ADDR(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  assign bus.busA = rf[bus.Ra];
  assign bus.busB = rf[bus.Rb];
  always @(posedge clk) if (bus.wrEn) begin
    rf[bus.Rw] <= bus.busW;
    wr_cnt     <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] o, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d);
    bus.in_valid = v; bus.op = o; bus.ra = a; bus.rb = b; bus.rd = d;
  endtask

  logic [3:0]  t_op [10] = '{4'd2, 4'd3, 4'd4, 4'd8, 4'd5, 4'd6, 4'd7, 4'd9, 4'd0, 4'd1};
  logic [4:0]  t_a  [10] = '{5'd1, 5'd1, 5'd1, 5'd2, 5'd6, 5'd10, 5'd10, 5'd1, 5'd5, 5'd7};
  logic [4:0]  t_b  [10] = '{5'd2, 5'd2, 5'd2, 5'd1, 5'd11, 5'd11, 5'd11, 5'd2, 5'd6, 5'd7};
  logic [15:0] t_r  [10] = '{16'h0021, 16'hFF77, 16'hFF56, 16'h0001, 16'h0010, 16'h0800, 16'hF800,
                             16'h0223, 16'h8000, 16'h0000};
  logic        t_z  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        t_v  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 16'd547; rf[2] = 16'hFD75; rf[5] = 16'h7FFF; rf[6] = 16'd1; rf[7] = 16'd5;
    rf[10] = 16'h8000; rf[11] = 16'd4; rf[13] = 16'd4576; rf[14] = 16'd8;
    rst = 1'b1;
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
    #1 rst = 1'b0;
    drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd3);
    repeat (3) step();
    check("rst_wren", bus.wrEn, 0);
    check("rst_busw", bus.busW, 0);
    check("rst_ready", bus.in_ready, 1);
    check("rst_flags", {bus.zero, bus.ovf}, 0);
    check("rst_nowrite", wr_cnt, 0);
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
    rst = 1'b1;
    step();

    drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd3);
    step();
    check("add_busw", bus.busW, 16'hFF98);
    check("add_wren", bus.wrEn, 1);
    check("add_rw", bus.Rw, 3);
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
    step();
    check("add_pulse", bus.wrEn, 0);
    check("add_commit", rf[3], 16'hFF98);

    drive(1'b1, 4'd0, 5'd1, 5'd1, 5'd3);
    step();
    check("fwd_first", bus.busW, 16'd1094);
    drive(1'b1, 4'd1, 5'd3, 5'd2, 5'd4);
    step();
    check("fwd_sub", bus.busW, 16'd1745);
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
    step();
    check("fwd_commit", rf[4], 16'd1745);

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, t_op[i], t_a[i], t_b[i], 5'd20 + 5'(i));
      step();
      check($sformatf("vec%0d_busw", i), bus.busW, t_r[i]);
      check($sformatf("vec%0d_flags", i), {bus.wrEn, bus.zero, bus.ovf}, {1'b1, t_z[i], t_v[i]});
    end

    base = wr_cnt + 1;
    drive(1'b1, 4'd12, 5'd1, 5'd2, 5'd30);
    step();
    check("nop_wren", bus.wrEn, 0);
    check("nop_hold", {bus.busW, bus.zero, bus.ovf}, {16'h0000, 1'b1, 1'b0});
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
    step();
    check("nop_nowrite", wr_cnt, base);

    base = wr_cnt;
    drive(1'b1, 4'd10, 5'd13, 5'd14, 5'd15);
    step();
    drive(1'b1, 4'd0, 5'd15, 5'd1, 5'd16);
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.wrEn) break;
      if (!bus.in_ready) busy++;
      step();
    end
    check("mul_busy", busy, 16);
    check("mul_wren", bus.wrEn, 1);
    check("mul_busw", bus.busW, 16'h8F00);
    check("mul_rw", bus.Rw, 15);
    check("mul_flags", {bus.zero, bus.ovf}, 0);
    check("mul_ignored", wr_cnt, base);
    step();
    check("post_mul_fwd", bus.busW, 16'h9123);
    check("post_mul_rw", bus.Rw, 16);
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
    step();
    check("mul_commit", rf[15], 16'h8F00);

    drive(1'b1, 4'd10, 5'd13, 5'd14, 5'd17);
    step();
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
    repeat (7) step();
    rst = 1'b0;
    #1;
    check("abort_ready", bus.in_ready, 1);
    check("abort_wren", bus.wrEn, 0);
    step();
    rst = 1'b1;
    base = wr_cnt;
    repeat (20) step();
    check("abort_nowrite", wr_cnt, base);
    check("abort_rd", rf[17], 0);
    drive(1'b1, 4'd0, 5'd1, 5'd2, 5'd18);
    step();
    check("after_abort_add", {bus.wrEn, bus.busW}, {1'b1, 16'hFF98});
    drive(1'b0, 4'd0, 5'd0, 5'd0, 5'd0);
    step();
    check("after_abort_commit", rf[18], 16'hFF98);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
